// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle CPU datapath.
// Accepts one MemRead/MemWrite request at a time, waits LATENCY cycles,
// performs the access on an internal word-addressed RAM and answers with a
// one-cycle MemReady pulse. Misaligned, out-of-range and read+write
// requests are answered on the same schedule but flagged with MemError.
// LATENCY must lie in 1..15 (the wait counter is four bits wide), and
// ADDR_WIDTH must be at most 29 so that the word index fits in Address.

module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        MemError
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            count;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_wdata;
    logic                  lat_read;
    logic                  lat_write;
    logic [31:0]           ram [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] index;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  conflict;
    logic                  bad_req;
    logic                  do_access;
    logic                  do_write;

    // Request classification works only on the values captured at acceptance
    assign index        = lat_addr[ADDR_WIDTH+1:2];
    assign misaligned   = (lat_addr[1:0] != 2'b00);
    assign out_of_range = ((lat_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign conflict     = lat_read & lat_write;
    assign bad_req      = misaligned | out_of_range | conflict;

    // The access happens on the edge that moves WAIT into RESP
    assign do_access = (state == WAIT) && (count == 4'd0);
    assign do_write  = do_access && lat_write && !bad_req;

    // RAM array: no reset so contents survive a reset, written only for a good write
    always_ff @(posedge clk) begin
        if (do_write) begin
            ram[index] <= lat_wdata;
        end
    end

    // Request sequencer with registered handshake outputs and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            ReadData  <= 32'd0;
            MemReady  <= 1'b0;
            MemBusy   <= 1'b0;
            MemError  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    MemReady <= 1'b0;
                    MemError <= 1'b0;
                    if (MemRead || MemWrite) begin
                        lat_addr  <= Address;
                        lat_wdata <= WriteData;
                        lat_read  <= MemRead;
                        lat_write <= MemWrite;
                        count     <= 4'(LATENCY - 1);
                        MemBusy   <= 1'b1;
                        state     <= WAIT;
                    end else begin
                        MemBusy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state    <= RESP;
                        MemReady <= 1'b1;
                        MemError <= bad_req;
                        if (bad_req) begin
                            ReadData <= 32'd0;
                        end else if (lat_read) begin
                            ReadData <= ram[index];
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    MemReady <= 1'b0;
                    MemBusy  <= 1'b0;
                    MemError <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    MemReady <= 1'b0;
                    MemBusy  <= 1'b0;
                    MemError <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder. Three instances with LATENCY 2, 1
// and 4 share clock, reset and request inputs; each keeps its own RAM.
// Instance 0 (LATENCY=2) carries the functional checks, the other two are
// used for the latency sweep.

module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;

    logic [31:0] rd_data [3];
    logic        rdy     [3];
    logic        busy    [3];
    logic        errf    [3];

    int          checks;
    int          errors;

    int          lat_q   [3];
    int          busy_q  [3];
    int          pulse_q [3];
    logic [31:0] data_q  [3];
    logic        err_q   [3];

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write),
        .Address(address), .WriteData(write_data), .ReadData(rd_data[0]),
        .MemReady(rdy[0]), .MemBusy(busy[0]), .MemError(errf[0])
    );

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut_lat1 (
        .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write),
        .Address(address), .WriteData(write_data), .ReadData(rd_data[1]),
        .MemReady(rdy[1]), .MemBusy(busy[1]), .MemError(errf[1])
    );

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(4)) dut_lat4 (
        .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write),
        .Address(address), .WriteData(write_data), .ReadData(rd_data[2]),
        .MemReady(rdy[2]), .MemBusy(busy[2]), .MemError(errf[2])
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One request on all instances; records latency, busy length, pulse count,
    // and data/error seen with the first MemReady. Called #1 after an edge,
    // returns #1 after an edge with every instance back in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic disturb);
        applyStimulus(rd, wr, addr, wdata);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, addr, wdata);
        for (int d = 0; d < 3; d++) begin
            lat_q[d]   = -1;
            busy_q[d]  = 0;
            pulse_q[d] = 0;
            data_q[d]  = 32'hFFFF_FFFF;
            err_q[d]   = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            for (int d = 0; d < 3; d++) begin
                if (busy[d]) busy_q[d]++;
                if (rdy[d]) begin
                    pulse_q[d]++;
                    if (lat_q[d] < 0) begin
                        lat_q[d]  = k;
                        data_q[d] = rd_data[d];
                        err_q[d]  = errf[d];
                    end
                end
            end
            if (disturb && k == 1) applyStimulus(1'b0, 1'b1, 32'h20, 32'hBAD0_BAD0);
            if (disturb && k == 2) applyStimulus(1'b0, 1'b0, addr, wdata);
        end
    endtask

    int          pulse_at   [3];
    logic [31:0] pulse_data [3];
    int          npulse;
    logic [31:0] next_addr;

    // Directed test sequence
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_readdata", rd_data[0], 32'd0);
        checkOutput("reset_ready",    32'(rdy[0]),  32'd0);
        checkOutput("reset_busy",     32'(busy[0]), 32'd0);
        checkOutput("reset_error",    32'(errf[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Write 0x12345678 to 0x04, with latency sweep on all instances
        access(1'b0, 1'b1, 32'h04, 32'h1234_5678, 1'b0);
        checkOutput("wr_latency",       32'(lat_q[0]),  32'd2);
        checkOutput("wr_error",         32'(err_q[0]),  32'd0);
        checkOutput("wr_busy_cycles",   32'(busy_q[0]), 32'd3);
        checkOutput("wr_pulses",        32'(pulse_q[0]), 32'd1);
        checkOutput("lat1_latency",     32'(lat_q[1]),  32'd1);
        checkOutput("lat1_busy_cycles", 32'(busy_q[1]), 32'd2);
        checkOutput("lat4_latency",     32'(lat_q[2]),  32'd4);
        checkOutput("lat4_busy_cycles", 32'(busy_q[2]), 32'd5);

        // Read back 0x04; data must be held after the pulse
        access(1'b1, 1'b0, 32'h04, 32'd0, 1'b0);
        checkOutput("rd_latency",   32'(lat_q[0]), 32'd2);
        checkOutput("rd_data",      data_q[0],     32'h1234_5678);
        checkOutput("rd_error",     32'(err_q[0]), 32'd0);
        checkOutput("lat4_rd_data", data_q[2],     32'h1234_5678);
        checkOutput("rd_data_held", rd_data[0],    32'h1234_5678);
        checkOutput("rd_idle_ready", 32'(rdy[0]),  32'd0);
        checkOutput("rd_idle_busy",  32'(busy[0]), 32'd0);

        // Reset in the middle of a write wait must abort it
        access(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("midrst_readdata", rd_data[0],    32'd0);
        checkOutput("midrst_ready",    32'(rdy[0]),   32'd0);
        checkOutput("midrst_busy",     32'(busy[0]),  32'd0);
        checkOutput("midrst_error",    32'(errf[0]),  32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
        checkOutput("midrst_no_commit", data_q[0], 32'd0);

        // Preload words used by later tests
        access(1'b0, 1'b1, 32'h00, 32'h1111_0000, 1'b0);
        access(1'b0, 1'b1, 32'h08, 32'h2222_0008, 1'b0);
        access(1'b0, 1'b1, 32'h20, 32'h3333_0020, 1'b0);

        // Misaligned read
        access(1'b1, 1'b0, 32'h06, 32'd0, 1'b0);
        checkOutput("misalign_error",   32'(err_q[0]), 32'd1);
        checkOutput("misalign_data",    data_q[0],     32'd0);
        checkOutput("misalign_latency", 32'(lat_q[0]), 32'd2);
        checkOutput("error_clears",     32'(errf[0]),  32'd0);

        // Out-of-range write must not alias onto word 0
        access(1'b0, 1'b1, 32'h400, 32'hBADB_AD00, 1'b0);
        checkOutput("range_error", 32'(err_q[0]), 32'd1);
        checkOutput("range_data",  data_q[0],     32'd0);
        access(1'b1, 1'b0, 32'h00, 32'd0, 1'b0);
        checkOutput("range_ram_kept", data_q[0],     32'h1111_0000);
        checkOutput("range_rd_ok",    32'(err_q[0]), 32'd0);

        // Read and write together
        access(1'b1, 1'b1, 32'h08, 32'hCAFE_0000, 1'b0);
        checkOutput("conflict_error", 32'(err_q[0]), 32'd1);
        access(1'b1, 1'b0, 32'h08, 32'd0, 1'b0);
        checkOutput("conflict_ram_kept", data_q[0], 32'h2222_0008);

        // Strobes and address toggled during the wait of a read
        access(1'b1, 1'b0, 32'h20, 32'd0, 1'b1);
        checkOutput("ignore_pulses",      32'(pulse_q[0]), 32'd1);
        checkOutput("ignore_data",        data_q[0],       32'h3333_0020);
        checkOutput("ignore_lat4_pulses", 32'(pulse_q[2]), 32'd1);
        checkOutput("ignore_busy_idle",   32'(busy[0]),    32'd0);
        access(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
        checkOutput("ignore_no_write", data_q[0], 32'h3333_0020);

        // Back-to-back reads with the strobe held high
        for (int i = 0; i < 3; i++) begin
            pulse_at[i]   = 0;
            pulse_data[i] = 32'hFFFF_FFFF;
        end
        npulse    = 0;
        next_addr = 32'h04;
        applyStimulus(1'b1, 1'b0, 32'h00, 32'd0);
        for (int c = 1; c <= 30 && npulse < 3; c++) begin
            @(posedge clk); #1;
            if (rdy[0]) begin
                pulse_at[npulse]   = c;
                pulse_data[npulse] = rd_data[0];
                npulse++;
                address   = next_addr;
                next_addr = next_addr + 32'd4;
            end else if (busy[0]) begin
                address = 32'hFC;
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'd0);
        checkOutput("b2b_count",   32'(npulse),                    32'd3);
        checkOutput("b2b_first",   32'(pulse_at[0]),               32'd3);
        checkOutput("b2b_space1",  32'(pulse_at[1] - pulse_at[0]), 32'd4);
        checkOutput("b2b_space2",  32'(pulse_at[2] - pulse_at[1]), 32'd4);
        checkOutput("b2b_data0",   pulse_data[0],                  32'h1111_0000);
        checkOutput("b2b_data1",   pulse_data[1],                  32'h1234_5678);
        checkOutput("b2b_data2",   pulse_data[2],                  32'h2222_0008);
        repeat (10) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
